// File: rtl/or_bitwise_pkg.sv
// Shared ALU definitions: datapath width and word type.
package or_bitwise_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef logic [ALU_WIDTH-1:0] alu_word_t;

endpackage : or_bitwise_pkg

// File: rtl/or_bit_slice.sv
// Single-bit OR with enable gating; one instance per datapath bit.
module or_bit_slice (
    input  logic i_a,
    input  logic i_b,
    input  logic i_en,
    output logic o_y
);

    assign o_y = i_en & (i_a | i_b);

endmodule : or_bit_slice

// File: rtl/or_bitwise.sv
// Registered bitwise-OR unit with enable gating, valid qualification and zero flag.
module or_bitwise
    import or_bitwise_pkg::*;
#(
    parameter int unsigned WIDTH      = ALU_WIDTH,
    parameter bit          HAS_ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_1,
    input  logic [WIDTH-1:0] i_2,
    input  logic             enable,
    input  logic             in_valid,
    output logic [WIDTH-1:0] o,
    output logic             out_valid,
    output logic             o_zero
);

    logic             w_enable_eff;
    logic [WIDTH-1:0] w_or;
    logic             w_zero;

    logic [WIDTH-1:0] r_o;
    logic             r_zero;
    logic             r_valid;

    assign w_enable_eff = HAS_ENABLE ? enable : 1'b1;

    // One OR slice per bit; no cross-bit interaction.
    for (genvar k = 0; k < WIDTH; k++) begin : g_slice
        or_bit_slice u_slice (
            .i_a  (i_1[k]),
            .i_b  (i_2[k]),
            .i_en (w_enable_eff),
            .o_y  (w_or[k])
        );
    end

    assign w_zero = ~(|w_or);

    // Result and flag hold when no valid sample; valid itself is never held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o     <= '0;
            r_zero  <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_o    <= w_or;
                r_zero <= w_zero;
            end
        end
    end

    assign o         = r_o;
    assign o_zero    = r_zero;
    assign out_valid = r_valid;

endmodule : or_bitwise

// File: tb/tb_or_bitwise.sv
// Self-checking bench for or_bitwise: directed cases plus randomized traffic against a reference model.
module tb_or_bitwise;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_1;
    logic [31:0] i_2;
    logic        enable;
    logic        in_valid;
    logic [31:0] o;
    logic        out_valid;
    logic        o_zero;

    int unsigned n_checks;
    int unsigned n_errors;

    // Reference state: what the outputs should show right now.
    logic [31:0] exp_o;
    logic        exp_z;
    logic        exp_v;

    or_bitwise dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_1       (i_1),
        .i_2       (i_2),
        .enable    (enable),
        .in_valid  (in_valid),
        .o         (o),
        .out_valid (out_valid),
        .o_zero    (o_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".o"},         o,                 exp_o);
        check_eq({tag, ".o_zero"},    32'(o_zero),       32'(exp_z));
        check_eq({tag, ".out_valid"}, 32'(out_valid),    32'(exp_v));
    endtask

    task automatic model_reset();
        exp_o = 32'h0;
        exp_z = 1'b1;
        exp_v = 1'b0;
    endtask

    // Drive one cycle of inputs, advance past the edge, update model and compare.
    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic en, input logic v);
        i_1      = a;
        i_2      = b;
        enable   = en;
        in_valid = v;
        @(posedge clk);
        #1;
        if (v) begin
            exp_o = en ? (a | b) : 32'h0;
            exp_z = (exp_o == 32'h0);
        end
        exp_v = v;
        check_outputs(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        i_1      = $urandom;
        i_2      = $urandom;
        enable   = 1'b1;
        in_valid = 1'b1;
        model_reset();

        // Edges during reset must not capture operands.
        repeat (3) begin
            @(posedge clk);
            #1;
            i_1 = $urandom;
            i_2 = $urandom;
        end
        check_outputs("reset");

        @(negedge clk);
        rst_n = 1'b1;

        apply("basic",    32'h0000129F, 32'h00000BD2, 1'b1, 1'b1);
        check_eq("basic.value", o, 32'h00001BDF);
        apply("sat",      32'hFFFFFFFF, 32'hA8492525, 1'b1, 1'b1);
        check_eq("sat.value", o, 32'hFFFFFFFF);
        apply("ident",    32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
        apply("zero",     32'h00000000, 32'h00000000, 1'b1, 1'b1);
        check_eq("zero.flag", 32'(o_zero), 32'd1);
        apply("mixed",    32'hFF8FE94B, 32'hFFFC4A3F, 1'b1, 1'b1);
        check_eq("mixed.value", o, 32'hFFFFEB7F);
        apply("en_off",   32'hFFA521FF, 32'h80000007, 1'b0, 1'b1);
        apply("en_on",    32'hFFA521FF, 32'h80000007, 1'b1, 1'b1);
        check_eq("en_on.value", o, 32'hFFA521FF);
        apply("hold0",    32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0);
        apply("hold1",    32'hDEADBEEF, 32'h00000001, 1'b0, 1'b0);
        check_eq("hold.value", o, 32'hFFA521FF);

        // Reset mid-stream clears outputs without a clock edge.
        apply("pre_rst",  32'hC0000000, 32'h00000003, 1'b1, 1'b1);
        i_1 = 32'hFFFFFFFF;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        en;
            logic        v;
            a  = $urandom;
            b  = $urandom;
            // Bias toward sparse operands so zero results occur.
            if ($urandom_range(0, 3) == 0) a = a & 32'(1 << $urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) b = 32'h0;
            en = ($urandom_range(0, 4) != 0);
            v  = ($urandom_range(0, 3) != 0);
            apply("rand", a, b, en, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_or_bitwise

// File: doc/or_bitwise.md
# or_bitwise

Registered 32-bit bitwise-OR unit for the ALU datapath. It samples two operands on each clock edge, forms their bitwise OR, and presents the result one cycle later. The result is gated by an enable and qualified by a valid flag. A zero flag is provided for the ALU status logic.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits (must be ≥ 1).
- `HAS_ENABLE`, default 1: when 0, the `enable` input is ignored and treated as constant 1.

Ports:
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `i_1` input, WIDTH bits: operand A.
- `i_2` input, WIDTH bits: operand B.
- `enable` input, 1 bit: 1 passes the OR result; 0 forces the result to zero.
- `in_valid` input, 1 bit: operands are meaningful this cycle.
- `o` output, WIDTH bits: registered result.
- `out_valid` output, 1 bit: `o` corresponds to a valid input sampled on the previous edge.
- `o_zero` output, 1 bit: registered flag, 1 when `o` is all zeros.

## Operation
- Combinational stage computes `r = enable_eff ? (i_1 | i_2) : '0`, where `enable_eff = HAS_ENABLE ? enable : 1'b1`.
- On each rising edge with `in_valid = 1`:
  - `o <= r`
  - `o_zero <= (r == 0)`
  - `out_valid <= 1`
- On each rising edge with `in_valid = 0`:
  - `o` and `o_zero` hold their previous values.
  - `out_valid <= 0`
- The OR operation is bit-independent: bit k of `o` depends only on bit k of `i_1`, bit k of `i_2`, and the enable. There is no carry or cross-bit interaction.
- X or Z on an operand bit does not propagate to other bits.

## Timing
- Latency: 1 clock cycle from a valid sample to `out_valid`/`o`.
- Throughput: one operation per cycle; no backpressure and no stall input.
- Reset (`rst_n = 0`, asynchronous assert):
  - `o = 0`
  - `o_zero = 1`
  - `out_valid = 0`
- Reset release is synchronous to `clk`. The first sample is taken on the first rising edge with `rst_n = 1`.
- Reset asserted mid-stream discards any in-flight result immediately; there is no partial update.
- `enable` is sampled on the same edge as the operands. An enable change affects only the result of that edge, never a result already registered.
- `enable = 0` with `in_valid = 1` produces a valid zero result: `out_valid = 1`, `o = 0`, `o_zero = 1`.

## Structure
- Shared ALU package holds:
  - `ALU_WIDTH = 32`
  - typedef `alu_word_t` (`logic [ALU_WIDTH-1:0]`)
- Natural sub-module: `or_bit_slice`, a per-bit OR with enable gating. It is instantiated WIDTH times via generate.
- The top level contains the generate loop, the zero-detect reduction, and the output registers.

## Test plan
- Reset: hold `rst_n = 0` and drive arbitrary operands -> `o = 0`, `o_zero = 1`, `out_valid = 0`. Assert `rst_n` low mid-stream -> outputs clear immediately, without waiting for a clock edge.
- Basic OR: `i_1 = 0x0000129F`, `i_2 = 0x00000BD2`, `enable = 1`, `in_valid = 1` -> next cycle `o = 0x00001BDF`, `o_zero = 0`, `out_valid = 1`.
- Saturation and identity, issued back-to-back on consecutive cycles:
  - `0xFFFFFFFF | 0xA8492525` -> `0xFFFFFFFF`
  - `0xFFFFFFFF | 0x00000000` -> `0xFFFFFFFF`
  - `0x00000000 | 0x00000000` -> `0x00000000` with `o_zero = 1`
- Mixed pattern: `0xFF8FE94B | 0xFFFC4A3F` -> `0xFFFFEB7F`.
- Enable gating: `enable = 0`, `0xFFA521FF | 0x80000007` -> `o = 0`, `o_zero = 1`, `out_valid = 1`. Then `enable = 1` with the same operands -> `0xFFA521FF`.
- Valid hold: `in_valid = 0` while operands toggle -> `o` and `o_zero` unchanged, `out_valid = 0`.
